// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite responder with a prescaled down-counting timer and level interrupt.
// Optional macro AXI_TIMER_SLVERR_EN: answer unmapped offsets and COUNT writes with SLVERR.
module axi_lite_timer_slave #(
   parameter int PRESCALE_W  = 16,
   parameter int COUNT_W     = 32,
   parameter int OFFSET_BITS = 12
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_axi_awvalid,
   output logic        o_axi_awready,
   input  logic [31:0] i_axi_awaddr,
   input  logic [2:0]  i_axi_awprot,
   input  logic        i_axi_wvalid,
   output logic        o_axi_wready,
   input  logic [31:0] i_axi_wdata,
   input  logic [3:0]  i_axi_wstrb,
   output logic        o_axi_bvalid,
   input  logic        i_axi_bready,
   output logic [1:0]  o_axi_bresp,
   input  logic        i_axi_arvalid,
   output logic        o_axi_arready,
   input  logic [31:0] i_axi_araddr,
   input  logic [2:0]  i_axi_arprot,
   output logic        o_axi_rvalid,
   input  logic        i_axi_rready,
   output logic [31:0] o_axi_rdata,
   output logic [1:0]  o_axi_rresp,
   output logic        o_irq
);

   localparam int WW = OFFSET_BITS - 2;
   localparam logic [WW-1:0] W_CTRL   = WW'(0);
   localparam logic [WW-1:0] W_STATUS = WW'(1);
   localparam logic [WW-1:0] W_LOAD   = WW'(2);
   localparam logic [WW-1:0] W_COUNT  = WW'(3);
   localparam logic [WW-1:0] W_PRESC  = WW'(4);

   logic                  live_q;
   logic                  aw_full_q, w_full_q;
   logic [WW-1:0]         aw_word_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [31:0]           rdata_q;
   logic                  en_q, autoreload_q, irqen_q, expired_q, irq_q;
   logic [COUNT_W-1:0]    load_q, count_q;
   logic [PRESCALE_W-1:0] prescale_q, presc_cnt_q;

   logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, do_write;
   logic [WW-1:0]         wr_word, rd_word;
   logic [31:0]           wr_data;
   logic [3:0]            wr_strb;
   logic [31:0]           ctrl_word, status_word, load_word, count_word, presc_word;
   logic [31:0]           ctrl_m, load_m, presc_m;
   logic                  wr_ctrl, wr_status, wr_load, wr_presc, status_clr, tick;
   logic [31:0]           rd_val;
   logic [1:0]            wr_resp, rd_resp;
   logic                  unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   // live_q holds all ready outputs low until the first cycle after reset
   assign o_axi_awready = live_q & ~aw_full_q & ~bvalid_q;
   assign o_axi_wready  = live_q & ~w_full_q & ~bvalid_q;
   assign o_axi_arready = live_q & ~rvalid_q;
   assign o_axi_bvalid  = bvalid_q;
   assign o_axi_bresp   = bresp_q;
   assign o_axi_rvalid  = rvalid_q;
   assign o_axi_rdata   = rdata_q;
   assign o_axi_rresp   = rresp_q;
   assign o_irq         = irq_q;

   assign aw_hs    = i_axi_awvalid & o_axi_awready;
   assign w_hs     = i_axi_wvalid & o_axi_wready;
   assign ar_hs    = i_axi_arvalid & o_axi_arready;
   assign b_hs     = bvalid_q & i_axi_bready;
   assign r_hs     = rvalid_q & i_axi_rready;
   assign do_write = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~bvalid_q;

   assign wr_word = aw_full_q ? aw_word_q : i_axi_awaddr[OFFSET_BITS-1:2];
   assign wr_data = w_full_q ? w_data_q : i_axi_wdata;
   assign wr_strb = w_full_q ? w_strb_q : i_axi_wstrb;
   assign rd_word = i_axi_araddr[OFFSET_BITS-1:2];

   assign ctrl_word   = {29'b0, irqen_q, autoreload_q, en_q};
   assign status_word = {31'b0, expired_q};
   assign load_word   = 32'(load_q);
   assign count_word  = 32'(count_q);
   assign presc_word  = 32'(prescale_q);

   assign ctrl_m  = merge_bytes(ctrl_word, wr_data, wr_strb);
   assign load_m  = merge_bytes(load_word, wr_data, wr_strb);
   assign presc_m = merge_bytes(presc_word, wr_data, wr_strb);

   assign tick       = en_q & (presc_cnt_q == prescale_q);
   assign status_clr = wr_status & wr_strb[0] & wr_data[0];

   always_comb begin
      wr_ctrl   = 1'b0;
      wr_status = 1'b0;
      wr_load   = 1'b0;
      wr_presc  = 1'b0;
      if (do_write) begin
         case (wr_word)
            W_CTRL:   wr_ctrl   = 1'b1;
            W_STATUS: wr_status = 1'b1;
            W_LOAD:   wr_load   = 1'b1;
            W_PRESC:  wr_presc  = 1'b1;
            default:  ;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (rd_word)
         W_CTRL:   rd_val = ctrl_word;
         W_STATUS: rd_val = status_word;
         W_LOAD:   rd_val = load_word;
         W_COUNT:  rd_val = count_word;
         W_PRESC:  rd_val = presc_word;
         default:  rd_val = '0;
      endcase
   end

`ifdef AXI_TIMER_SLVERR_EN
   assign wr_resp = ((wr_word == W_COUNT) || (wr_word > W_PRESC)) ? 2'b10 : 2'b00;
   assign rd_resp = (rd_word > W_PRESC) ? 2'b10 : 2'b00;
`else
   assign wr_resp = 2'b00;
   assign rd_resp = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         live_q    <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         aw_word_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
      end else begin
         live_q <= 1'b1;
         if (aw_hs) begin
            aw_full_q <= 1'b1;
            aw_word_q <= i_axi_awaddr[OFFSET_BITS-1:2];
         end
         if (w_hs) begin
            w_full_q <= 1'b1;
            w_data_q <= i_axi_wdata;
            w_strb_q <= i_axi_wstrb;
         end
         if (do_write) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end
         // holders stay occupied until the response is taken
         if (b_hs) begin
            bvalid_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_resp;
         end else if (r_hs) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         en_q         <= 1'b0;
         autoreload_q <= 1'b0;
         irqen_q      <= 1'b0;
         expired_q    <= 1'b0;
         irq_q        <= 1'b0;
         load_q       <= '0;
         count_q      <= '0;
         prescale_q   <= '0;
         presc_cnt_q  <= '0;
      end else begin
         if (status_clr) begin
            expired_q <= 1'b0;
         end
         if (!en_q || tick) begin
            presc_cnt_q <= '0;
         end else begin
            presc_cnt_q <= presc_cnt_q + PRESCALE_W'(1);
         end
         // a terminal tick after the clear so that a coinciding set wins
         if (tick) begin
            if (count_q != '0) begin
               count_q <= count_q - COUNT_W'(1);
            end else begin
               expired_q <= 1'b1;
               if (autoreload_q) begin
                  count_q <= load_q;
               end else begin
                  en_q <= 1'b0;
               end
            end
         end
         if (wr_ctrl && wr_strb[0]) begin
            en_q         <= ctrl_m[0];
            autoreload_q <= ctrl_m[1];
            irqen_q      <= ctrl_m[2];
            if (!ctrl_m[0]) begin
               presc_cnt_q <= '0;
            end
         end
         if (wr_load) begin
            load_q <= load_m[COUNT_W-1:0];
            if (!en_q) begin
               count_q <= load_m[COUNT_W-1:0];
            end
         end
         if (wr_presc) begin
            prescale_q <= presc_m[PRESCALE_W-1:0];
         end
         irq_q <= expired_q & irqen_q;
      end
   end

   assign unused_bits = ^{i_axi_awprot, i_axi_arprot,
                          i_axi_awaddr[31:OFFSET_BITS], i_axi_awaddr[1:0],
                          i_axi_araddr[31:OFFSET_BITS], i_axi_araddr[1:0],
                          ctrl_m[31:3], load_m, presc_m};

endmodule

// File: tb/tb_axi_lite_timer_slave.sv
// Directed bench for axi_lite_timer_slave: register access, handshakes, timer and interrupt timing.
module tb_axi_lite_timer_slave;

   logic        clk = 1'b0;
   logic        resetn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, irq;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef AXI_TIMER_SLVERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   always #5 clk = ~clk;

   axi_lite_timer_slave dut (
      .clk           (clk),
      .resetn        (resetn),
      .i_axi_awvalid (awvalid),
      .o_axi_awready (awready),
      .i_axi_awaddr  (awaddr),
      .i_axi_awprot  (3'b000),
      .i_axi_wvalid  (wvalid),
      .o_axi_wready  (wready),
      .i_axi_wdata   (wdata),
      .i_axi_wstrb   (wstrb),
      .o_axi_bvalid  (bvalid),
      .i_axi_bready  (bready),
      .o_axi_bresp   (bresp),
      .i_axi_arvalid (arvalid),
      .o_axi_arready (arready),
      .i_axi_araddr  (araddr),
      .i_axi_arprot  (3'b000),
      .o_axi_rvalid  (rvalid),
      .i_axi_rready  (rready),
      .o_axi_rdata   (rdata),
      .o_axi_rresp   (rresp),
      .o_irq         (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Starts and ends on a falling edge; AW/W raised after their own delays.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
      int   c;
      logic aw_done, w_done, aw_hs, w_hs;
      c = 0; aw_done = 1'b0; w_done = 1'b0;
      awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
      while (!(aw_done && w_done) && c < 40) begin
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         aw_hs   = awvalid && awready;
         w_hs    = wvalid && wready;
         @(negedge clk);
         c++;
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("b_latency", {31'b0, bvalid}, 32'd1);
      while (!bvalid && c < 40) begin
         @(negedge clk);
         c++;
      end
      resp = bresp;
      @(negedge clk);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int   c;
      logic hs;
      c = 0; hs = 1'b0;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      while (!hs && c < 40) begin
         hs = arready;
         @(negedge clk);
         c++;
      end
      arvalid = 1'b0;
      check("r_latency", {31'b0, rvalid}, 32'd1);
      data = rdata;
      resp = rresp;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rsp;
      int          extra;

      resetn = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      repeat (3) @(negedge clk);
      check("reset_ctl", {24'b0, awready, wready, arready, bvalid, rvalid, irq, bresp[0], rresp[0]}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {29'b0, awready, wready, arready}, 32'd7);
      axi_read(32'h08, rd, rsp);
      check("load_reset", rd, 32'd0);

      // AW first, W three cycles later
      axi_write(32'h08, 32'h10, 4'hF, 0, 3, rsp);
      check("aw_first_bresp", rsp, 2'b00);
      axi_read(32'h0C, rd, rsp);
      check("count_copy", rd, 32'h10);

      // W first, then simultaneous AW+W
      axi_write(32'h10, 32'h5, 4'hF, 2, 0, rsp);
      check("w_first_bresp", rsp, 2'b00);
      extra = 0;
      repeat (3) begin extra += int'(bvalid); @(negedge clk); end
      check("w_first_single_b", extra, 0);
      axi_read(32'h10, rd, rsp);
      check("presc_5", rd, 32'h5);
      axi_write(32'h10, 32'h3, 4'hF, 0, 0, rsp);
      extra = 0;
      repeat (3) begin extra += int'(bvalid); @(negedge clk); end
      check("same_cycle_single_b", extra, 0);
      axi_read(32'h10, rd, rsp);
      check("presc_3", rd, 32'h3);

      // byte strobes, upper address bits ignored
      axi_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, rsp);
      axi_write(32'h08, 32'h11223344, 4'b0101, 0, 0, rsp);
      axi_read(32'h08, rd, rsp);
      check("load_strobe", rd, 32'hAA22CC44);
      axi_read(32'h1234_500C, rd, rsp);
      check("count_strobe_alias", rd, 32'hAA22CC44);
      axi_write(32'h00, 32'hFFFF_FFF6, 4'hF, 0, 0, rsp);
      axi_read(32'h00, rd, rsp);
      check("ctrl_mask", rd, 32'h6);
      axi_write(32'h00, 32'h0, 4'hF, 0, 0, rsp);

      // illegal accesses
      axi_write(32'h0C, 32'h55, 4'hF, 0, 0, rsp);
      check("count_write_bresp", rsp, ERR_RESP);
      axi_read(32'h0C, rd, rsp);
      check("count_unchanged", rd, 32'hAA22CC44);
      axi_read(32'h20, rd, rsp);
      check("unmapped_rdata", rd, 32'd0);
      check("unmapped_rresp", rsp, ERR_RESP);
      axi_write(32'h40, 32'h1, 4'hF, 0, 0, rsp);
      check("unmapped_bresp", rsp, ERR_RESP);

      // read and write of LOAD in the same cycle
      araddr = 32'h08; arvalid = 1'b1; rready = 1'b1;
      awaddr = 32'h08; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      check("rw_same_old", rdata, 32'hAA22CC44);
      check("rw_same_b", {31'b0, bvalid}, 32'd1);
      @(negedge clk);
      axi_read(32'h08, rd, rsp);
      check("rw_same_new", rd, 32'h1234);

      // one-shot, PRESCALE=0
      axi_write(32'h08, 32'h2, 4'hF, 0, 0, rsp);
      axi_write(32'h10, 32'h0, 4'hF, 0, 0, rsp);
      axi_write(32'h00, 32'h5, 4'hF, 0, 0, rsp);
      @(negedge clk);
      check("irq_early1", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("irq_early2", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'b0, irq}, 32'd1);
      axi_read(32'h00, rd, rsp);
      check("en_cleared", rd, 32'h4);
      axi_read(32'h04, rd, rsp);
      check("expired_set", rd, 32'h1);
      axi_read(32'h0C, rd, rsp);
      check("count_zero", rd, 32'h0);
      axi_write(32'h04, 32'h1, 4'b1110, 0, 0, rsp);
      axi_read(32'h04, rd, rsp);
      check("clear_needs_strb0", rd, 32'h1);
      awaddr = 32'h04; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("irq_hold_after_clear", {31'b0, irq}, 32'd1);
      @(negedge clk);
      check("irq_fall", {31'b0, irq}, 32'd0);

      // one-shot, PRESCALE=3: COUNT read as 2,1,0
      axi_write(32'h08, 32'h2, 4'hF, 0, 0, rsp);
      axi_write(32'h10, 32'h3, 4'hF, 0, 0, rsp);
      axi_write(32'h00, 32'h5, 4'hF, 0, 0, rsp);
      axi_read(32'h0C, rd, rsp);
      check("count_2", rd, 32'h2);
      repeat (2) @(negedge clk);
      axi_read(32'h0C, rd, rsp);
      check("count_1", rd, 32'h1);
      repeat (2) @(negedge clk);
      axi_read(32'h0C, rd, rsp);
      check("count_0", rd, 32'h0);
      check("p3_irq_a", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("p3_irq_b", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("p3_irq_c", {31'b0, irq}, 32'd1);
      axi_write(32'h04, 32'h1, 4'hF, 0, 0, rsp);

      // autoreload, LOAD=1, PRESCALE=1: expiry every 4 cycles
      axi_write(32'h08, 32'h1, 4'hF, 0, 0, rsp);
      axi_write(32'h10, 32'h1, 4'hF, 0, 0, rsp);
      axi_write(32'h00, 32'h3, 4'hF, 0, 0, rsp);
      axi_read(32'h0C, rd, rsp);
      check("ar_count_a", rd, 32'h1);
      axi_read(32'h0C, rd, rsp);
      check("ar_count_b", rd, 32'h0);
      axi_read(32'h0C, rd, rsp);
      check("ar_count_c", rd, 32'h1);
      axi_read(32'h04, rd, rsp);
      check("ar_expired", rd, 32'h1);
      axi_write(32'h04, 32'h1, 4'hF, 0, 0, rsp);
      axi_read(32'h04, rd, rsp);
      check("ar_cleared", rd, 32'h0);
      axi_write(32'h04, 32'h1, 4'hF, 0, 0, rsp);
      axi_write(32'h04, 32'h1, 4'hF, 0, 0, rsp);
      axi_read(32'h04, rd, rsp);
      check("set_beats_clear", rd, 32'h1);
      axi_read(32'h00, rd, rsp);
      check("ar_en_kept", rd, 32'h3);
      axi_write(32'h00, 32'h0, 4'hF, 0, 0, rsp);
      axi_write(32'h04, 32'h1, 4'hF, 0, 0, rsp);

      // R backpressure
      axi_write(32'h10, 32'h7, 4'hF, 0, 0, rsp);
      araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      araddr = 32'h10;
      for (int i = 0; i < 5; i++) begin
         check("r_stall_ctl", {30'b0, rvalid, arready}, 32'd2);
         check("r_stall_data", rdata, 32'h1);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      check("arready_back", {31'b0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      check("queued_read", rdata, 32'h7);
      @(negedge clk);

      // B backpressure
      bready = 1'b0;
      awaddr = 32'h10; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      wdata = 32'hB;
      for (int i = 0; i < 4; i++) begin
         check("b_stall", {29'b0, awready, wready, bvalid}, 32'd1);
         @(negedge clk);
      end
      axi_read(32'h10, rd, rsp);
      check("b_stall_one_write", rd, 32'h9);
      check("b_stall_still_blocked", {30'b0, awready, wready}, 32'd0);
      bready = 1'b1;
      @(negedge clk);
      check("b_release_ready", {30'b0, awready, wready}, 32'd3);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("second_b", {31'b0, bvalid}, 32'd1);
      @(negedge clk);
      axi_read(32'h10, rd, rsp);
      check("second_write", rd, 32'hB);

      // reset with a B and an R pending
      awaddr = 32'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("pending_before_reset", {30'b0, bvalid, rvalid}, 32'd3);
      resetn = 1'b0;
      @(negedge clk);
      check("mid_reset", {27'b0, bvalid, rvalid, awready, wready, arready}, 32'd0);
      resetn = 1'b1; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      extra = 0;
      repeat (3) begin extra += int'(bvalid) + int'(rvalid); @(negedge clk); end
      check("no_stale_resp", extra, 0);
      axi_read(32'h08, rd, rsp);
      check("load_after_reset", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_timer_slave.md
Name: axi_lite_timer_slave

Overview:
- AXI4-Lite responder holding a memory-mapped down-counting timer with prescaler and interrupt output.
- Sits on the CPU AXI4-Lite bus beside data memory, behind the system address decoder.
- Answers the picorv32 AXI initiator's read and write transactions, with independent read and write channels.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and counter.
- COUNT_W, 32, width of the LOAD and COUNT registers (max 32).
- OFFSET_BITS, 12, number of low address bits decoded. Upper address bits are ignored, because the external decoder handles them.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset
- i_axi_awvalid  input  1  write address valid
- o_axi_awready  output  1  write address ready
- i_axi_awaddr  input  32  write address
- i_axi_awprot  input  3  ignored
- i_axi_wvalid  input  1  write data valid
- o_axi_wready  output  1  write data ready
- i_axi_wdata  input  32  write data
- i_axi_wstrb  input  4  byte strobes
- o_axi_bvalid  output  1  write response valid
- i_axi_bready  input  1  write response ready
- o_axi_bresp  output  2  OKAY=00, SLVERR=10
- i_axi_arvalid  input  1  read address valid
- o_axi_arready  output  1  read address ready
- i_axi_araddr  input  32  read address
- i_axi_arprot  input  3  ignored
- o_axi_rvalid  output  1  read data valid
- i_axi_rready  input  1  read data ready
- o_axi_rdata  output  32  read data
- o_axi_rresp  output  2  read response
- o_irq  output  1  timer interrupt, level

Behaviour:
- Reset and clocking:
  - One clock domain. Reset is synchronous and active-low (resetn sampled on the rising clk edge).
  - Reset values: all valid/ready outputs 0; bresp, rresp, rdata 0; o_irq 0; all registers 0.
  - Ready outputs rise on the first cycle after reset deasserts.
- Register map (offset = addr[OFFSET_BITS-1:0], word aligned; addr[1:0] ignored):
  - 0x00 CTRL: [0] EN, [1] AUTORELOAD, [2] IRQEN. Read/write; other bits read 0.
  - 0x04 STATUS: [0] EXPIRED. Write-1-to-clear via wstrb[0].
  - 0x08 LOAD: reload value. Read/write.
  - 0x0C COUNT: read-only. Writes are dropped and answered with SLVERR.
  - 0x10 PRESCALE: read/write, PRESCALE_W bits.
  - Any other offset is unmapped and answered with SLVERR.
- Write strobes: honoured per byte lane on CTRL, LOAD and PRESCALE.
- Write channel:
  - AW and W are captured independently into one-deep holding registers, in either order or in the same cycle.
  - awready = AW holder empty and no B pending. wready = W holder empty and no B pending.
  - When both holders are full, the register update takes place on that edge. bvalid is asserted the next cycle.
  - bvalid and bresp are held until bready; both holders free on the B handshake.
  - Minimum latency: AW+W handshake at cycle N, bvalid at N+1.
- Read channel:
  - arready = !rvalid.
  - An AR handshake at cycle N gives rvalid at N+1, with rdata/rresp registered.
  - rdata and rresp stay stable until rready; arready reasserts the cycle after the R handshake.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Timer:
  - The prescaler counts 0..PRESCALE while EN=1 and emits a tick when it equals PRESCALE, then wraps to 0. PRESCALE=0 gives a tick every cycle.
  - On a tick with COUNT>0: COUNT decrements.
  - On a tick with COUNT==0: EXPIRED is set. With AUTORELOAD=1, COUNT reloads from LOAD; otherwise EN is cleared and COUNT holds 0.
  - Writing LOAD while EN=0 also copies the value into COUNT. Writing LOAD while EN=1 affects the next reload only.
  - Clearing EN resets the prescaler to 0.
  - A STATUS clear coinciding with a set: set wins, EXPIRED stays 1.
- o_irq is registered: EXPIRED & IRQEN, one cycle after either changes.
- Reset mid-transaction: all pending handshakes are dropped, and no B or R response is issued for them.

Optional Feature:
- Macro: AXI_TIMER_SLVERR_EN.
- Defined: unmapped offsets and writes to COUNT return resp=10 (SLVERR).
- Undefined: all responses are OKAY (00), unmapped reads return 0x0000_0000, and the illegal writes are silently dropped.

Test Plan:
- AW then W three cycles later, to 0x08 with 0x0000_0010 and wstrb=F -> one bvalid, bresp=00; a read of 0x0C returns 0x10 (EN=0).
- W before AW, and AW+W in the same cycle, to 0x10 with 0x0000_0003 -> each gives exactly one B response; a read of 0x10 returns 3.
- LOAD=2, PRESCALE=0, CTRL=0x5 -> COUNT reads 2,1,0; EXPIRED=1 and o_irq=1 one cycle after the zero tick; EN reads 0.
  - Then write 0x1 to STATUS -> o_irq falls one cycle later.
- AUTORELOAD with LOAD=1, PRESCALE=1 -> EXPIRED is set every 4 cycles and COUNT cycles 1,0,1.
- Read 0x20 and write 0x0C with the macro defined -> rresp=10 and bresp=10, COUNT unchanged. Without the macro -> resp=00, rdata=0.
- Hold rready low for 5 cycles -> rdata stable and arready low. Hold bready low -> awready and wready low, and no second write is accepted.
